// File: rtl/timer_bank.sv
// Bank of N_CH independent down-counting timers behind a word-addressed register file.
// Each channel has a prescaler, a one-shot/auto-reload FSM, a sticky flag and an interrupt mask.
module timer_bank #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [N_CH-1:0]   irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  logic [7:0]       ctrl_q   [N_CH];
  logic [7:0]       ctrl_d   [N_CH];
  logic [CNT_W-1:0] preset_q [N_CH];
  logic [CNT_W-1:0] preset_d [N_CH];
  logic [CNT_W-1:0] count_q  [N_CH];
  logic [CNT_W-1:0] count_d  [N_CH];
  logic [15:0]      ps_cnt_q [N_CH];
  logic [15:0]      ps_cnt_d [N_CH];
  logic [1:0]       state_q  [N_CH];
  logic [1:0]       state_d  [N_CH];
  logic [N_CH-1:0]  flag_q;
  logic [N_CH-1:0]  flag_d;

  logic [N_CH-1:0]  wr_ctrl;
  logic [N_CH-1:0]  wr_preset;
  logic [N_CH-1:0]  wr_status;
  logic [N_CH-1:0]  tick;
  logic [15:0]      ps_mask  [N_CH];

  logic [3:0] ch_sel;
  logic [1:0] reg_sel;

  assign ch_sel  = {1'b0, addr[4:2]};
  assign reg_sel = addr[1:0];

  // Address decode; channels at or beyond N_CH never match, so their writes vanish.
  always_comb begin
    wr_ctrl   = '0;
    wr_preset = '0;
    wr_status = '0;
    tick      = '0;
    for (int i = 0; i < N_CH; i++) begin
      ps_mask[i]   = (16'd1 << ctrl_q[i][7:4]) - 16'd1;
      tick[i]      = (ps_cnt_q[i] >= ps_mask[i]);
      wr_ctrl[i]   = we && (ch_sel == 4'(i)) && (reg_sel == REG_CTRL);
      wr_preset[i] = we && (ch_sel == 4'(i)) && (reg_sel == REG_PRESET);
      wr_status[i] = we && (ch_sel == 4'(i)) && (reg_sel == REG_STATUS);
    end
  end

  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < N_CH; i++) begin
      ctrl_d[i]   = wr_ctrl[i] ? wdata[7:0] : ctrl_q[i];
      preset_d[i] = wr_preset[i] ? wdata[CNT_W-1:0] : preset_q[i];
      count_d[i]  = count_q[i];
      ps_cnt_d[i] = ps_cnt_q[i];
      state_d[i]  = state_q[i];
      if (wr_status[i] && wdata[0]) begin
        flag_d[i] = 1'b0;
      end

      // EN decisions use the post-write value so a software disable acts on its own edge.
      case (state_q[i])
        ST_IDLE: begin
          if (ctrl_d[i][0]) begin
            state_d[i] = ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_d[i]  = preset_q[i];
          ps_cnt_d[i] = '0;
          state_d[i]  = ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_d[i][0]) begin
            state_d[i] = ST_IDLE;
          end else begin
            ps_cnt_d[i] = tick[i] ? 16'd0 : ps_cnt_q[i] + 16'd1;
            if (tick[i]) begin
              if (count_q[i] <= CNT_W'(1)) begin
                count_d[i] = '0;
                flag_d[i]  = 1'b1;
                state_d[i] = ST_DONE;
              end else begin
                count_d[i] = count_q[i] - CNT_W'(1);
              end
            end
          end
        end
        default: begin
          if ((ctrl_q[i][2:1] == MODE_RELOAD) && ctrl_d[i][0]) begin
            state_d[i] = ST_LOAD;
          end else begin
            state_d[i]   = ST_IDLE;
            ctrl_d[i][0] = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    irq   = '0;
    for (int i = 0; i < N_CH; i++) begin
      irq[i] = flag_q[i] & ctrl_q[i][3];
      if (ch_sel == 4'(i)) begin
        case (reg_sel)
          REG_CTRL:   rdata = {24'd0, ctrl_q[i]};
          REG_PRESET: rdata = 32'(preset_q[i]);
          REG_COUNT:  rdata = 32'(count_q[i]);
          default:    rdata = {31'd0, flag_q[i]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        ctrl_q[i]   <= '0;
        preset_q[i] <= '0;
        count_q[i]  <= '0;
        ps_cnt_q[i] <= '0;
        state_q[i]  <= ST_IDLE;
      end
    end else begin
      flag_q <= flag_d;
      for (int i = 0; i < N_CH; i++) begin
        ctrl_q[i]   <= ctrl_d[i];
        preset_q[i] <= preset_d[i];
        count_q[i]  <= count_d[i];
        ps_cnt_q[i] <= ps_cnt_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed plus random bench for timer_bank; a per-channel behavioural model predicts
// every register read and the irq vector after each clock edge.
module tb_timer_bank;
  localparam int N_CH  = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       addr;
  logic             we;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [N_CH-1:0]  irq;

  timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: a channel is either waiting, about to load, counting, or just expired.
  logic [7:0]  m_ctrl     [N_CH];
  logic [31:0] m_preset   [N_CH];
  logic [31:0] m_count    [N_CH];
  bit          m_flag     [N_CH];
  bit          m_load_pend[N_CH];
  bit          m_running  [N_CH];
  bit          m_done_pend[N_CH];
  int          m_age      [N_CH];

  int os_seq [8];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    int ch;
    ch = int'(a[4:2]);
    if (ch >= N_CH) return 32'd0;
    case (a[1:0])
      2'd0:    return {24'd0, m_ctrl[ch]};
      2'd1:    return m_preset[ch];
      2'd2:    return m_count[ch];
      default: return {31'd0, m_flag[ch]};
    endcase
  endfunction

  function automatic logic [31:0] exp_irq();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) r[i] = m_flag[i] & m_ctrl[i][3];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_ctrl[i] = '0; m_preset[i] = '0; m_count[i] = '0; m_flag[i] = 0;
      m_load_pend[i] = 0; m_running[i] = 0; m_done_pend[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_edge(input logic w, input logic [4:0] a, input logic [31:0] d);
    logic [7:0] nctrl;
    bit hit, en, set_f, clr, tk;
    int period;
    for (int i = 0; i < N_CH; i++) begin
      hit    = w && (int'(a[4:2]) == i);
      nctrl  = (hit && a[1:0] == 2'd0) ? d[7:0] : m_ctrl[i];
      en     = nctrl[0];
      clr    = hit && (a[1:0] == 2'd3) && d[0];
      set_f  = 0;
      period = 1 << m_ctrl[i][7:4];
      if (m_load_pend[i]) begin
        m_count[i] = m_preset[i];
        m_age[i] = 0;
        m_load_pend[i] = 0;
        m_running[i] = 1;
      end else if (m_running[i]) begin
        if (!en) m_running[i] = 0;
        else begin
          tk = ((m_age[i] + 1) % period) == 0;
          m_age[i]++;
          if (tk) begin
            if (m_count[i] <= 1) begin
              m_count[i] = 0; set_f = 1; m_running[i] = 0; m_done_pend[i] = 1;
            end else m_count[i] = m_count[i] - 1;
          end
        end
      end else if (m_done_pend[i]) begin
        m_done_pend[i] = 0;
        if (m_ctrl[i][2:1] == 2'b01 && en) m_load_pend[i] = 1;
        else nctrl[0] = 1'b0;
      end else if (en) m_load_pend[i] = 1;
      if (hit && a[1:0] == 2'd1) m_preset[i] = d;
      m_ctrl[i] = nctrl;
      if (set_f) m_flag[i] = 1;
      else if (clr) m_flag[i] = 0;
    end
  endtask

  // One clock: check a read, present the (optional) write, advance model and DUT together.
  task automatic apply_stimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                                input logic [4:0] ra);
    we = 1'b0; addr = ra; wdata = '0;
    #1 check_output("read", rdata, exp_read(ra));
    we = w; addr = a; wdata = d;
    #1;
    if (w) check_output("read_during_write", rdata, exp_read(a));
    model_edge(w, a, d);
    @(posedge clk);
    cyc++;
    #1 check_output("irq", 32'(irq), exp_irq());
    we = 1'b0;
  endtask

  task automatic idle_step(input logic [4:0] ra);
    apply_stimulus(1'b0, 5'd0, 32'd0, ra);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    apply_stimulus(1'b1, a, d, a);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    we = 1'b0; addr = a;
    #1 v = rdata;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] v;
    int rises, last;
    bit prev;
    os_seq = '{0, 5, 4, 3, 2, 1, 0, 0};

    reset = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_reset();
    #1;
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      #1 check_output("reset_read", rdata, 32'd0);
    end
    check_output("reset_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // One-shot ch0, PRESET=5, EN+IM.
    wr(5'd1, 32'd5);
    wr(5'd0, 32'h9);
    for (int k = 1; k < 8; k++) begin
      idle_step(5'd2);
      rd(5'd2, v);
      check_output("oneshot_count", v, 32'(os_seq[k]));
      check_output("oneshot_irq", 32'(irq[0]), (k >= 6) ? 32'd1 : 32'd0);
    end
    rd(5'd0, v);
    check_output("oneshot_ctrl", v, 32'h8);
    wr(5'd3, 32'd1);

    // Auto-reload ch1, PRESET=3: flag-set edges must be 5 cycles apart.
    wr(5'd5, 32'd3);
    wr(5'd4, 32'hB);
    rises = 0; last = -1; prev = 0;
    for (int k = 0; k < 60 && rises < 4; k++) begin
      if (irq[1] && !prev) begin
        rises++;
        if (last >= 0) check_output("reload_period", 32'(cyc - last), 32'd5);
        last = cyc;
      end
      prev = irq[1];
      if (irq[1] && rises < 4) apply_stimulus(1'b1, 5'd7, 32'd1, 5'd6);
      else idle_step(5'd6);
    end
    check_output("reload_rises", 32'(rises), 32'd4);
    while (cyc < last + 4) idle_step(5'd2);
    wr(5'd7, 32'd1);
    rd(5'd7, v);
    check_output("set_beats_clear", v, 32'd1);
    wr(5'd4, 32'd0);
    wr(5'd7, 32'd1);
    idle_step(5'd7);

    // Prescaler: PRESET=2, PS=2 -> flag 8 cycles after load.
    wr(5'd1, 32'd2);
    wr(5'd0, 32'h29);
    for (int k = 1; k < 10; k++) begin
      idle_step(5'd3);
      rd(5'd3, v);
      check_output("ps_flag", v, (k >= 9) ? 32'd1 : 32'd0);
    end
    wr(5'd3, 32'd1);

    // PRESET=0 behaves as 1 and never wraps.
    wr(5'd1, 32'd0);
    wr(5'd0, 32'h9);
    idle_step(5'd2);
    rd(5'd3, v);
    check_output("p0_noflag_at_load", v, 32'd0);
    idle_step(5'd2);
    rd(5'd3, v);
    check_output("p0_flag", v, 32'd1);
    rd(5'd2, v);
    check_output("p0_nowrap", v, 32'd0);
    repeat (3) idle_step(5'd2);
    wr(5'd3, 32'd1);

    // Disable mid-count at COUNT=3, then restart from PRESET.
    wr(5'd1, 32'd6);
    wr(5'd0, 32'h9);
    repeat (4) idle_step(5'd2);
    rd(5'd2, v);
    check_output("pre_stop_count", v, 32'd3);
    wr(5'd0, 32'h8);
    repeat (5) idle_step(5'd2);
    rd(5'd2, v);
    check_output("stop_hold", v, 32'd3);
    check_output("stop_irq", 32'(irq[0]), 32'd0);
    wr(5'd0, 32'h9);
    idle_step(5'd2);
    rd(5'd2, v);
    check_output("restart_count", v, 32'd6);
    repeat (8) idle_step(5'd3);
    wr(5'd3, 32'd1);

    // Nonexistent channel 5.
    wr(5'd21, 32'h1234);
    rd(5'd21, v);
    check_output("ch5_preset", v, 32'd0);
    rd(5'd1, v);
    check_output("ch0_preset_kept", v, 32'd6);
    rd(5'd5, v);
    check_output("ch1_preset_kept", v, 32'd3);

    // IM=0 with FLAG=1, then unmask without touching FLAG.
    wr(5'd1, 32'd1);
    wr(5'd0, 32'h1);
    repeat (4) idle_step(5'd3);
    check_output("masked_irq", 32'(irq[0]), 32'd0);
    rd(5'd3, v);
    check_output("masked_flag", v, 32'd1);
    wr(5'd0, 32'h8);
    check_output("unmasked_irq", 32'(irq[0]), 32'd1);
    wr(5'd3, 32'd1);
    check_output("cleared_irq", 32'(irq[0]), 32'd0);

    // Random traffic against the model.
    for (int it = 0; it < 600; it++) begin
      int ch, op;
      logic [4:0] base, ra;
      logic [31:0] d;
      bit quiet;
      ch = $urandom_range(0, N_CH - 1);
      op = $urandom_range(0, 7);
      base = 5'(ch * 4);
      ra = 5'($urandom_range(0, 31));
      quiet = !m_running[ch] && !m_load_pend[ch] && !m_done_pend[ch];
      case (op)
        0: begin
          d = 32'(($urandom_range(0, 2) << 4) | ($urandom_range(0, 1) << 3) |
                  ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
          if (quiet) apply_stimulus(1'b1, base, d, ra);
          else idle_step(ra);
        end
        1: apply_stimulus(1'b1, base + 5'd1, 32'($urandom_range(0, 6)), ra);
        2: apply_stimulus(1'b1, base + 5'd3, $urandom, ra);
        3: apply_stimulus(1'b1, base, {24'd0, m_ctrl[ch] ^ 8'h08}, ra);
        4: apply_stimulus(1'b1, base, {24'd0, m_ctrl[ch] & 8'hFE}, ra);
        5: begin
          if ($urandom_range(0, 1) == 1)
            apply_stimulus(1'b1, {3'($urandom_range(2, 7)), 2'($urandom_range(0, 3))}, $urandom, ra);
          else
            apply_stimulus(1'b1, base + 5'd2, $urandom, ra);
        end
        default: idle_step(ra);
      endcase
    end

    // Asynchronous reset in the middle of a count.
    wr(5'd1, 32'd50);
    wr(5'd0, 32'h9);
    repeat (5) idle_step(5'd2);
    #3 reset = 1'b0;
    model_reset();
    rd(5'd2, v);
    check_output("midreset_count", v, 32'd0);
    check_output("midreset_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) idle_step(5'd3);
    rd(5'd3, v);
    check_output("midreset_noflag", v, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
